lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Load/store front end that sits directly upstream of data_memory and drives its port (en, 4-bit byte write enable, address, write data), then consumes its one-cycle-latency read data.
- Turns RV32I load/store requests (funct3 encoded) into byte-strobed word accesses.
- Aligns, sign- or zero-extends the returned data.
- Splits misaligned accesses into two word accesses.
- Flags illegal accesses.

Parameters:
RAM_SPACE, 4096, data RAM depth in 32-bit words; must match data_memory.
WORD_AW, $clog2(RAM_SPACE), word-index width, derived; do not override.

Ports:
clk  in  1  core clock
rstn  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I width/sign code: 0 B, 1 H, 2 W, 4 BU, 5 HU
req_addr  in  32  byte address
req_wdata  in  32  store data, LSB-justified
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  illegal funct3 or out-of-range address; valid with resp_valid
mem_en  out  1  to data_memory en_mem
mem_w_en  out  4  to w_en_mem; bit i enables byte i
mem_addr  out  32  word-aligned byte address to addr_mem; bits[1:0] = 0
mem_w_data  out  32  to w_data_mem, lane-aligned
mem_r_data  in  32  from r_data_mem; valid the cycle after mem_en

Behaviour:
- Clock and reset: single clock clk. rstn is synchronous and active-low.
- Reset values: state IDLE, resp_valid=0, resp_err=0, resp_rdata=0, req_ready=0 in the reset cycle.
- mem_* outputs are combinational from the state and the accepted request. They are 0 whenever no access is issued.
- States: IDLE, RESP, SPLIT2.
- req_ready is 1 in IDLE and RESP and 0 in SPLIT2.
- Accept cycle T:
  - Legal, aligned: drive mem_en=1 at word addr[31:2]. Next state RESP. resp_valid at T+1.
  - Misaligned (H at offset 3, W at offset 1..3): drive word N at T and word N+1 at T+1 (state SPLIT2). Latch mem_r_data of word N at T+1. Next state RESP. resp_valid at T+2.
  - Illegal: no memory access, mem_en stays 0. Next state RESP. resp_valid at T+1 with resp_err=1 and resp_rdata=0.
  - Illegal means any of: funct3 in {3,6,7}; funct3 in {4,5} with req_we=1; addr[31:WORD_AW+2] nonzero; a misaligned second word index equal to RAM_SPACE (the word index does not wrap).
- RESP with a new request accepted: that request issues in the same cycle, giving back-to-back throughput of one aligned access per cycle. RESP with no request: return to IDLE.
- Stores, byte offset o = addr[1:0], 64-bit lane shift:
  - SB: w_en = 1<<o.
  - SH: w_en = 3<<o.
  - SW: w_en = 4'hF<<o.
  - The low 4 strobe bits and shifted data go to word N; the high 4 bits go to word N+1.
  - The second half is issued only if its strobe is nonzero.
- Loads: form a 64-bit value {word N+1, word N}, shift right by 8*o, then take the low byte, half or word.
  - B and H sign-extend; BU and HU zero-extend.
  - Aligned loads use word N only.
  - Read data is captured from mem_r_data exactly one cycle after the matching mem_en.
- Reset mid-operation: the next state is IDLE and no further mem_en is issued.
  - A misaligned store interrupted after its first half leaves that half written; this is accepted.
  - A pending resp_valid is dropped.
- resp_valid depends only on the issued request, never on req_valid in the same cycle.

Decomposition:
- Shared package holds the funct3 constants (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU), the state encoding, and the RAM_SPACE default.
- One natural sub-module: lsu_load_align, a combinational 64-to-32 shift plus extend block, reused by the later cache path.

Test Plan:
1. SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem_w_en=F, mem_addr=0x10; load resp_rdata=0xDEADBEEF at T+1, resp_err=0.
2. SB 0x21 data 0xAA, then LB 0x21 and LBU 0x21 -> mem_w_en=0x2, mem_w_data[15:8]=0xAA; LB gives 0xFFFFFFAA, LBU gives 0x000000AA.
3. SW addr 0x103 data 0x11223344 -> T: addr 0x100, w_en=0x8, byte3=0x44; T+1: addr 0x104, w_en=0x7, bytes 0x112233; resp_valid at T+2; LW 0x103 returns 0x11223344.
4. LW 0x3FFD (last word, misaligned; RAM_SPACE 4096) -> resp_err=1 at T+1, mem_en never asserted, resp_rdata=0.
5. funct3=3 and LW 0x10000 -> resp_err=1 for each, no memory access.
6. Back-to-back LW 0x0, LW 0x4, LW 0x8 on consecutive cycles -> three resp_valid pulses on T+1, T+2, T+3. Separately, assert rstn=0 at T+1 of a misaligned SW -> no second write and no resp_valid.

Source files
------------

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store memory front end: funct3 codes, FSM states,
// and the default data RAM depth.
package lsu_mem_ctrl_pkg;

   localparam int unsigned LSU_RAM_SPACE = 4096;

   localparam logic [2:0] LSU_B  = 3'd0;
   localparam logic [2:0] LSU_H  = 3'd1;
   localparam logic [2:0] LSU_W  = 3'd2;
   localparam logic [2:0] LSU_BU = 3'd4;
   localparam logic [2:0] LSU_HU = 3'd5;

   typedef enum logic [1:0] {
      StIdle,
      StResp,
      StSplit2
   } lsu_state_e;

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: selects the addressed byte/half/word from a two-word window
// and sign- or zero-extends it.
module lsu_load_align
   import lsu_mem_ctrl_pkg::*;
(
   input  logic [63:0] data,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] rdata
);

   logic [31:0] lane;
   logic        unused_top_byte;

   // The widest window needed is 24 + 32 bits, so the top byte never contributes.
   assign unused_top_byte = ^data[63:56];
   assign lane = data[{offset, 3'b000} +: 32];

   always_comb begin
      rdata = 32'h0;
      case (funct3)
         LSU_B:   rdata = {{24{lane[7]}}, lane[7:0]};
         LSU_H:   rdata = {{16{lane[15]}}, lane[15:0]};
         LSU_W:   rdata = lane;
         LSU_BU:  rdata = {24'h0, lane[7:0]};
         LSU_HU:  rdata = {16'h0, lane[15:0]};
         default: rdata = 32'h0;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store front end for data_memory: byte-strobed word accesses, misaligned
// accesses split into two words, aligned/extended load data and illegal-access flagging.
module lsu_mem_ctrl
   import lsu_mem_ctrl_pkg::*;
#(
   parameter int unsigned RAM_SPACE = LSU_RAM_SPACE,
   parameter int unsigned WORD_AW   = $clog2(RAM_SPACE)
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_en,
   output logic [3:0]  mem_w_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_w_data,
   input  logic [31:0] mem_r_data
);

   lsu_state_e  state_q, state_d;
   logic        err_q, err_d;
   logic        store_q, store_d;
   logic        split_q, split_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  off_q, off_d;
   logic [29:0] hi_word_q, hi_word_d;
   logic [3:0]  hi_wen_q, hi_wen_d;
   logic [31:0] hi_wdata_q, hi_wdata_d;
   logic [31:0] lo_word_q, lo_word_d;

   logic [3:0]  base_strb;
   logic        funct3_ok;
   logic [7:0]  strb8;
   logic [63:0] wdata64;
   logic [31:0] word_idx;
   logic        split;
   logic        illegal;
   logic        accept;
   logic [31:0] align_rdata;

   always_comb begin
      base_strb = 4'h0;
      funct3_ok = 1'b1;
      case (req_funct3)
         LSU_B, LSU_BU: base_strb = 4'h1;
         LSU_H, LSU_HU: base_strb = 4'h3;
         LSU_W:         base_strb = 4'hF;
         default:       funct3_ok = 1'b0;
      endcase
   end

   // Strobes and data are laid out over a two-word window; the upper half targets word N+1.
   assign strb8    = {4'h0, base_strb} << req_addr[1:0];
   assign wdata64  = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
   assign word_idx = {2'b00, req_addr[31:2]};
   assign split    = |strb8[7:4];

   assign illegal = !funct3_ok
                 || (req_we && req_funct3[2])
                 || ((req_addr >> (WORD_AW + 2)) != 32'h0)
                 || (word_idx >= RAM_SPACE)
                 || (split && (word_idx + 32'd1 >= RAM_SPACE));

   assign req_ready = rstn && (state_q != StSplit2);
   assign accept    = req_valid && req_ready;

   always_comb begin
      state_d    = state_q;
      err_d      = err_q;
      store_d    = store_q;
      split_d    = split_q;
      funct3_d   = funct3_q;
      off_d      = off_q;
      hi_word_d  = hi_word_q;
      hi_wen_d   = hi_wen_q;
      hi_wdata_d = hi_wdata_q;
      lo_word_d  = lo_word_q;
      mem_en     = 1'b0;
      mem_w_en   = 4'h0;
      mem_addr   = 32'h0;
      mem_w_data = 32'h0;

      case (state_q)
         StIdle, StResp: begin
            state_d = StIdle;
            if (accept) begin
               state_d    = (!illegal && split) ? StSplit2 : StResp;
               err_d      = illegal;
               store_d    = req_we;
               split_d    = split && !illegal;
               funct3_d   = req_funct3;
               off_d      = req_addr[1:0];
               hi_word_d  = req_addr[31:2] + 30'd1;
               hi_wen_d   = req_we ? strb8[7:4] : 4'h0;
               hi_wdata_d = req_we ? wdata64[63:32] : 32'h0;
               if (!illegal) begin
                  mem_en     = 1'b1;
                  mem_addr   = {req_addr[31:2], 2'b00};
                  mem_w_en   = req_we ? strb8[3:0] : 4'h0;
                  mem_w_data = req_we ? wdata64[31:0] : 32'h0;
               end
            end
         end
         StSplit2: begin
            state_d   = StResp;
            lo_word_d = mem_r_data;
            if (rstn) begin
               mem_en     = 1'b1;
               mem_addr   = {hi_word_q, 2'b00};
               mem_w_en   = hi_wen_q;
               mem_w_data = hi_wdata_q;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= StIdle;
         err_q      <= 1'b0;
         store_q    <= 1'b0;
         split_q    <= 1'b0;
         funct3_q   <= 3'h0;
         off_q      <= 2'h0;
         hi_word_q  <= 30'h0;
         hi_wen_q   <= 4'h0;
         hi_wdata_q <= 32'h0;
         lo_word_q  <= 32'h0;
      end else begin
         state_q    <= state_d;
         err_q      <= err_d;
         store_q    <= store_d;
         split_q    <= split_d;
         funct3_q   <= funct3_d;
         off_q      <= off_d;
         hi_word_q  <= hi_word_d;
         hi_wen_q   <= hi_wen_d;
         hi_wdata_q <= hi_wdata_d;
         lo_word_q  <= lo_word_d;
      end
   end

   lsu_load_align u_load_align (
      .data   (split_q ? {mem_r_data, lo_word_q} : {32'h0, mem_r_data}),
      .offset (off_q),
      .funct3 (funct3_q),
      .rdata  (align_rdata)
   );

   assign resp_valid = rstn && (state_q == StResp);
   assign resp_err   = resp_valid && err_q;
   assign resp_rdata = (resp_valid && !err_q && !store_q) ? align_rdata : 32'h0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl against a one-cycle-latency byte-enabled RAM model.
module tb_lsu_mem_ctrl;
   import lsu_mem_ctrl_pkg::*;

   logic        clk;
   logic        rstn;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_en;
   logic [3:0]  mem_w_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_w_data;
   logic [31:0] mem_r_data;

   int n_checks;
   int n_fail;
   int en_cnt;

   logic [31:0] ram [4096];

   lsu_mem_ctrl dut (
      .clk        (clk),
      .rstn       (rstn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_en     (mem_en),
      .mem_w_en   (mem_w_en),
      .mem_addr   (mem_addr),
      .mem_w_data (mem_w_data),
      .mem_r_data (mem_r_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_w_en[b]) ram[mem_addr[13:2]][8*b +: 8] <= mem_w_data[8*b +: 8];
         end
         mem_r_data <= ram[mem_addr[13:2]];
         en_cnt     <= en_cnt + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
      req_valid  = v;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = d;
   endtask

   task automatic test_reset();
      tick();
      drive(1'b1, 1'b0, LSU_W, 32'h10, 32'h0);
      #1;
      n_checks++;
      if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset req_ready: got %b want 0", req_ready); end
      n_checks++;
      if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset mem_en: got %b want 0", mem_en); end
      n_checks++;
      if ({resp_valid, resp_err, resp_rdata} !== 34'h0) begin
         n_fail++;
         $display("FAIL reset resp: got v=%b e=%b d=%h want all 0", resp_valid, resp_err, resp_rdata);
      end
      tick();
      drive(1'b0, 1'b0, LSU_W, 32'h0, 32'h0);
      rstn = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset idle: got ready=%b valid=%b want 1 0", req_ready, resp_valid);
      end
   endtask

   task automatic test_sw_lw();
      tick();
      drive(1'b1, 1'b1, LSU_W, 32'h10, 32'hDEADBEEF);
      #1;
      n_checks++;
      if ({mem_en, mem_w_en, mem_addr, mem_w_data} !== {1'b1, 4'hF, 32'h10, 32'hDEADBEEF}) begin
         n_fail++;
         $display("FAIL sw_issue: got en=%b we=%h a=%h d=%h want 1 f 10 deadbeef",
                  mem_en, mem_w_en, mem_addr, mem_w_data);
      end
      tick();
      drive(1'b1, 1'b0, LSU_W, 32'h10, 32'h0);
      #1;
      n_checks++;
      if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
         n_fail++;
         $display("FAIL sw_resp: got v=%b e=%b d=%h want 1 0 0", resp_valid, resp_err, resp_rdata);
      end
      n_checks++;
      if ({mem_en, mem_w_en, mem_addr} !== {1'b1, 4'h0, 32'h10}) begin
         n_fail++;
         $display("FAIL lw_issue: got en=%b we=%h a=%h want 1 0 10", mem_en, mem_w_en, mem_addr);
      end
      tick();
      drive(1'b0, 1'b0, LSU_W, 32'h0, 32'h0);
      #1;
      n_checks++;
      if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
         n_fail++;
         $display("FAIL lw_resp: got v=%b e=%b d=%h want 1 0 deadbeef", resp_valid, resp_err, resp_rdata);
      end
      tick();
      n_checks++;
      if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL lw_idle: got %b want 0", resp_valid); end
   endtask

   task automatic test_byte();
      tick();
      drive(1'b1, 1'b1, LSU_B, 32'h21, 32'h000000AA);
      #1;
      n_checks++;
      if ({mem_w_en, mem_addr, mem_w_data[15:8]} !== {4'h2, 32'h20, 8'hAA}) begin
         n_fail++;
         $display("FAIL sb_issue: got we=%h a=%h b1=%h want 2 20 aa", mem_w_en, mem_addr, mem_w_data[15:8]);
      end
      tick();
      drive(1'b1, 1'b0, LSU_B, 32'h21, 32'h0);
      #1;
      tick();
      drive(1'b1, 1'b0, LSU_BU, 32'h21, 32'h0);
      #1;
      n_checks++;
      if (resp_rdata !== 32'hFFFFFFAA) begin
         n_fail++;
         $display("FAIL lb_resp: got %h want ffffffaa", resp_rdata);
      end
      tick();
      drive(1'b0, 1'b0, LSU_W, 32'h0, 32'h0);
      #1;
      n_checks++;
      if (resp_rdata !== 32'h000000AA) begin
         n_fail++;
         $display("FAIL lbu_resp: got %h want 000000aa", resp_rdata);
      end
   endtask

   task automatic test_misaligned();
      tick();
      drive(1'b1, 1'b1, LSU_W, 32'h103, 32'h11223344);
      #1;
      n_checks++;
      if ({mem_en, mem_w_en, mem_addr, mem_w_data[31:24]} !== {1'b1, 4'h8, 32'h100, 8'h44}) begin
         n_fail++;
         $display("FAIL mis_first: got en=%b we=%h a=%h b3=%h want 1 8 100 44",
                  mem_en, mem_w_en, mem_addr, mem_w_data[31:24]);
      end
      tick();
      drive(1'b1, 1'b0, LSU_W, 32'h103, 32'h0);
      #1;
      n_checks++;
      if ({mem_en, mem_w_en, mem_addr, mem_w_data[23:0]} !== {1'b1, 4'h7, 32'h104, 24'h112233}) begin
         n_fail++;
         $display("FAIL mis_second: got en=%b we=%h a=%h d=%h want 1 7 104 112233",
                  mem_en, mem_w_en, mem_addr, mem_w_data[23:0]);
      end
      n_checks++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mis_stall: got ready=%b valid=%b want 0 0", req_ready, resp_valid);
      end
      tick();
      #1;
      n_checks++;
      if ({resp_valid, resp_err, req_ready, mem_addr, mem_w_en} !== {3'b101, 32'h100, 4'h0}) begin
         n_fail++;
         $display("FAIL mis_resp: got v=%b e=%b rdy=%b a=%h we=%h want 1 0 1 100 0",
                  resp_valid, resp_err, req_ready, mem_addr, mem_w_en);
      end
      tick();
      drive(1'b0, 1'b0, LSU_W, 32'h0, 32'h0);
      #1;
      n_checks++;
      if ({mem_en, mem_addr, resp_valid} !== {1'b1, 32'h104, 1'b0}) begin
         n_fail++;
         $display("FAIL mis_load2: got en=%b a=%h v=%b want 1 104 0", mem_en, mem_addr, resp_valid);
      end
      tick();
      n_checks++;
      if ({resp_valid, resp_rdata} !== {1'b1, 32'h11223344}) begin
         n_fail++;
         $display("FAIL mis_lw: got v=%b d=%h want 1 11223344", resp_valid, resp_rdata);
      end
   endtask

   task automatic test_range();
      int en0;
      tick();
      drive(1'b1, 1'b0, LSU_W, 32'h3FFC, 32'h0);
      #1;
      n_checks++;
      if ({mem_en, mem_addr} !== {1'b1, 32'h3FFC}) begin
         n_fail++;
         $display("FAIL last_word_issue: got en=%b a=%h want 1 3ffc", mem_en, mem_addr);
      end
      tick();
      drive(1'b1, 1'b0, LSU_W, 32'h3FFD, 32'h0);
      en0 = en_cnt;
      #1;
      n_checks++;
      if ({resp_valid, resp_err} !== 2'b10) begin
         n_fail++;
         $display("FAIL last_word_resp: got v=%b e=%b want 1 0", resp_valid, resp_err);
      end
      n_checks++;
      if (mem_en !== 1'b0) begin n_fail++; $display("FAIL range_mem_en: got %b want 0", mem_en); end
      tick();
      drive(1'b0, 1'b0, LSU_W, 32'h0, 32'h0);
      #1;
      n_checks++;
      if ({resp_valid, resp_err, resp_rdata} !== {2'b11, 32'h0}) begin
         n_fail++;
         $display("FAIL range_err: got v=%b e=%b d=%h want 1 1 0", resp_valid, resp_err, resp_rdata);
      end
      tick();
      n_checks++;
      if (en_cnt !== en0) begin n_fail++; $display("FAIL range_no_access: got %0d want %0d", en_cnt, en0); end
   endtask

   task automatic test_illegal();
      logic        we_v [3];
      logic [2:0]  f3_v [3];
      logic [31:0] a_v  [3];
      int          en0;
      we_v = '{1'b0, 1'b0, 1'b1};
      f3_v = '{3'd3, LSU_W, LSU_BU};
      a_v  = '{32'h10, 32'h10000, 32'h20};
      en0  = en_cnt;
      for (int i = 0; i < 3; i++) begin
         tick();
         drive(1'b1, we_v[i], f3_v[i], a_v[i], 32'h0);
         #1;
         n_checks++;
         if (mem_en !== 1'b0) begin n_fail++; $display("FAIL illegal_en[%0d]: got %b want 0", i, mem_en); end
         if (i > 0) begin
            n_checks++;
            if ({resp_valid, resp_err, resp_rdata} !== {2'b11, 32'h0}) begin
               n_fail++;
               $display("FAIL illegal_resp[%0d]: got v=%b e=%b d=%h want 1 1 0",
                        i - 1, resp_valid, resp_err, resp_rdata);
            end
         end
      end
      tick();
      drive(1'b0, 1'b0, LSU_W, 32'h0, 32'h0);
      #1;
      n_checks++;
      if ({resp_valid, resp_err} !== 2'b11) begin
         n_fail++;
         $display("FAIL illegal_resp[2]: got v=%b e=%b want 1 1", resp_valid, resp_err);
      end
      n_checks++;
      if (en_cnt !== en0) begin n_fail++; $display("FAIL illegal_no_access: got %0d want %0d", en_cnt, en0); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a_v [5];
      logic [31:0] d_v [5];
      a_v = '{32'h0, 32'h4, 32'h8, 32'h200, 32'h204};
      d_v = '{32'h01234567, 32'h89ABCDEF, 32'h13579BDF, 32'h0, 32'h55555555};
      for (int i = 0; i < 5; i++) begin
         tick();
         drive(1'b1, 1'b1, LSU_W, a_v[i], d_v[i]);
         #1;
         n_checks++;
         if ({mem_en, mem_addr} !== {1'b1, a_v[i]}) begin
            n_fail++;
            $display("FAIL b2b_store[%0d]: got en=%b a=%h want 1 %h", i, mem_en, mem_addr, a_v[i]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         drive(1'b1, 1'b0, LSU_W, a_v[i], 32'h0);
         #1;
         if (i > 0) begin
            n_checks++;
            if ({resp_valid, resp_rdata} !== {1'b1, d_v[i - 1]}) begin
               n_fail++;
               $display("FAIL b2b_load[%0d]: got v=%b d=%h want 1 %h", i - 1, resp_valid, resp_rdata,
                        d_v[i - 1]);
            end
         end
      end
      tick();
      drive(1'b0, 1'b0, LSU_W, 32'h0, 32'h0);
      #1;
      n_checks++;
      if ({resp_valid, resp_rdata} !== {1'b1, d_v[2]}) begin
         n_fail++;
         $display("FAIL b2b_load[2]: got v=%b d=%h want 1 %h", resp_valid, resp_rdata, d_v[2]);
      end
      tick();
      n_checks++;
      if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b want 0", resp_valid); end

      // Misaligned store interrupted by reset after its first half.
      drive(1'b1, 1'b1, LSU_W, 32'h203, 32'hCAFEF00D);
      tick();
      drive(1'b0, 1'b0, LSU_W, 32'h0, 32'h0);
      rstn = 1'b0;
      #1;
      n_checks++;
      if ({mem_en, resp_valid, req_ready} !== 3'b000) begin
         n_fail++;
         $display("FAIL rst_mid: got en=%b v=%b rdy=%b want 0 0 0", mem_en, resp_valid, req_ready);
      end
      tick();
      rstn = 1'b1;
      #1;
      n_checks++;
      if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_drop: got %b want 0", resp_valid); end
      drive(1'b1, 1'b0, LSU_W, 32'h200, 32'h0);
      tick();
      drive(1'b1, 1'b0, LSU_W, 32'h204, 32'h0);
      #1;
      n_checks++;
      if (resp_rdata !== 32'h0D000000) begin
         n_fail++;
         $display("FAIL rst_first_half: got %h want 0d000000", resp_rdata);
      end
      tick();
      drive(1'b0, 1'b0, LSU_W, 32'h0, 32'h0);
      #1;
      n_checks++;
      if (resp_rdata !== 32'h55555555) begin
         n_fail++;
         $display("FAIL rst_no_second: got %h want 55555555", resp_rdata);
      end
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      en_cnt     = 0;
      mem_r_data = 32'h0;
      rstn       = 1'b0;
      drive(1'b0, 1'b0, LSU_W, 32'h0, 32'h0);
      test_reset();
      test_sw_lw();
      test_byte();
      test_misaligned();
      test_range();
      test_illegal();
      test_back_to_back();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
